// File: rtl/mem_model_pkg.sv
// Shared types and helpers for the latency-modelling memory responder.
// Provides the default response payload, the stall FSM state encoding and
// the address range check.
package mem_model_pkg;

    // Default data width of the package-level response payload.
    localparam int unsigned PKG_MEM_W = 32;

    // One response-pipeline entry.
    typedef struct packed {
        logic                 valid;
        logic                 err;
        logic [PKG_MEM_W-1:0] rdata;
    } resp_t;

    typedef enum logic {
        OPEN  = 1'b0,
        STALL = 1'b1
    } stall_state_e;

    // Address lies inside a power-of-two sized memory (upper bits all zero).
    function automatic logic in_range(input logic [63:0] addr, input logic [63:0] size);
        return addr < size;
    endfunction

endpackage

// File: rtl/mem_resp_delay.sv
// Fixed-depth response delay line with synchronous clear.
// Ports:
//   clk, rst  - clock and synchronous active-high clear
//   in_i      - entry loaded into stage 0 every cycle
//   out_o     - last stage (registered)
module mem_resp_delay
    import mem_model_pkg::*;
#(
    parameter int unsigned LATENCY   = 1,
    parameter type         resp_el_t = resp_t
) (
    input  logic     clk,
    input  logic     rst,
    input  resp_el_t in_i,
    output resp_el_t out_o
);

    resp_el_t stage_q [LATENCY];
    resp_el_t stage_d [LATENCY];

    // Shift one stage per cycle; stage 0 always takes the new entry.
    always_comb begin
        stage_d[0] = in_i;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_o = stage_q[LATENCY-1];

endmodule

// File: rtl/mem_latency_model.sv
// Word-addressed memory responder with configurable latency, req/gnt
// handshake with periodic stall injection, out-of-range error responses and
// an outstanding-response counter.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_i/gnt_o         - request handshake (accept when both high)
//   addr_i/we_i/be_i/wdata_i - byte address, write flag, lane enables, data
//   rvalid_o/err_o/rdata_o   - one-cycle response, zero when idle
//   pending_o           - accepted requests not yet responded to
module mem_latency_model
    import mem_model_pkg::*;
#(
    parameter int unsigned MEM_W        = 32,
    parameter int unsigned MEM_SZ       = 262144,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STALL_EVERY  = 0,
    parameter int unsigned STALL_CYCLES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_i,
    output logic                             gnt_o,
    input  logic [ADDR_W-1:0]                addr_i,
    input  logic                             we_i,
    input  logic [MEM_W/8-1:0]               be_i,
    input  logic [MEM_W-1:0]                 wdata_i,
    output logic                             rvalid_o,
    output logic                             err_o,
    output logic [MEM_W-1:0]                 rdata_o,
    output logic [$clog2(MEM_LATENCY+1)-1:0] pending_o
);

    localparam int unsigned BE_W   = MEM_W / 8;
    localparam int unsigned OFF_W  = $clog2(BE_W);
    localparam int unsigned DEPTH  = MEM_SZ / BE_W;
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned PEND_W = $clog2(MEM_LATENCY + 1);
    localparam int unsigned ACC_W  = (STALL_EVERY > 0) ? $clog2(STALL_EVERY + 1) : 1;
    localparam int unsigned STC_W  = $clog2(STALL_CYCLES + 1);

    // Response entry sized for this instance's data width.
    typedef struct packed {
        logic             valid;
        logic             err;
        logic [MEM_W-1:0] rdata;
    } resp_line_t;

    logic [MEM_W-1:0]  mem_q [DEPTH];

    stall_state_e      state_q, state_d;
    logic [ACC_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [STC_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              gnt_q, gnt_d;
    logic [PEND_W-1:0] pending_q, pending_d;

    logic              acc_c;
    logic              in_rng_c;
    logic              wr_en_c;
    logic [IDX_W-1:0]  idx_c;
    logic [MEM_W-1:0]  rd_word_c;
    logic [MEM_W-1:0]  wr_word_c;
    resp_line_t        resp_in_c;
    resp_line_t        resp_last;

    // Acceptance; an edge with rst high never accepts.
    assign acc_c     = req_i & gnt_q & ~rst;
    assign in_rng_c  = in_range(64'(addr_i), 64'(MEM_SZ));
    assign idx_c     = addr_i[OFF_W +: IDX_W];
    assign rd_word_c = mem_q[idx_c];

    // Byte-lane merge of write data over the current word.
    always_comb begin
        wr_word_c = rd_word_c;
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (be_i[i]) begin
                wr_word_c[8*i +: 8] = wdata_i[8*i +: 8];
            end
        end
        wr_en_c = acc_c & we_i & in_rng_c;
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[idx_c] <= wr_word_c;
        end
    end

    // Response captured at the acceptance edge; read data is the pre-write word.
    always_comb begin
        resp_in_c       = '0;
        resp_in_c.valid = acc_c;
        resp_in_c.err   = acc_c & ~in_rng_c;
        resp_in_c.rdata = (acc_c & in_rng_c) ? rd_word_c : '0;
    end

    mem_resp_delay #(
        .LATENCY   (MEM_LATENCY),
        .resp_el_t (resp_line_t)
    ) u_delay (
        .clk   (clk),
        .rst   (rst),
        .in_i  (resp_in_c),
        .out_o (resp_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= OPEN;
            acc_cnt_q   <= '0;
            stall_cnt_q <= '0;
            gnt_q       <= 1'b0;
            pending_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            gnt_q       <= gnt_d;
            pending_q   <= pending_d;
        end
    end

    // Next-state: count acceptances while open, count down while stalled.
    always_comb begin
        state_d     = state_q;
        acc_cnt_d   = acc_cnt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            OPEN: begin
                if ((STALL_EVERY != 0) && acc_c) begin
                    if (acc_cnt_q == ACC_W'(STALL_EVERY - 1)) begin
                        state_d     = STALL;
                        acc_cnt_d   = '0;
                        stall_cnt_d = STC_W'(STALL_CYCLES - 1);
                    end else begin
                        acc_cnt_d = acc_cnt_q + ACC_W'(1);
                    end
                end
            end
            STALL: begin
                if (stall_cnt_q == '0) begin
                    state_d = OPEN;
                end else begin
                    stall_cnt_d = stall_cnt_q - STC_W'(1);
                end
            end
            default: state_d = OPEN;
        endcase
    end

    // Outputs: grant follows the upcoming state; pending tracks accept vs issue.
    always_comb begin
        gnt_d     = (state_d == OPEN);
        pending_d = pending_q + PEND_W'(acc_c) - PEND_W'(resp_last.valid);
    end

    assign gnt_o     = gnt_q;
    assign pending_o = pending_q;
    assign rvalid_o  = resp_last.valid;
    assign err_o     = resp_last.err;
    assign rdata_o   = resp_last.rdata;

endmodule

// File: tb/tb_mem_latency_model.sv
// Directed bench for mem_latency_model: two instances (latency 3 without
// stalls; latency 4 with a stall every 4 accepts for 2 cycles), a reference
// memory model and per-instance expected-response queues.
module tb_mem_latency_model;

    localparam int unsigned LAT0 = 3;
    localparam int unsigned LAT1 = 4;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        bit          chk;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [2];
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [3:0]  be    [2];
    logic [31:0] wdata [2];

    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [1:0]  pend0;
    logic [2:0]  pend1;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    bit          mon_en       = 0;
    int          rsp_cnt    [2];
    int          err_cnt    [2];
    logic [31:0] last_rdata [2];

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [31:0] m0 [int unsigned];
    logic [31:0] m1 [int unsigned];

    always @(posedge clk) cyc <= cyc + 1;

    mem_latency_model #(
        .MEM_W(32), .MEM_SZ(262144), .ADDR_W(32),
        .MEM_LATENCY(LAT0), .STALL_EVERY(0), .STALL_CYCLES(2)
    ) dut0 (
        .clk(clk), .rst(rst[0]), .req_i(req[0]), .gnt_o(gnt0), .addr_i(addr[0]),
        .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid0),
        .err_o(err0), .rdata_o(rdata0), .pending_o(pend0)
    );

    mem_latency_model #(
        .MEM_W(32), .MEM_SZ(262144), .ADDR_W(32),
        .MEM_LATENCY(LAT1), .STALL_EVERY(4), .STALL_CYCLES(2)
    ) dut1 (
        .clk(clk), .rst(rst[1]), .req_i(req[1]), .gnt_o(gnt1), .addr_i(addr[1]),
        .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid1),
        .err_o(err1), .rdata_o(rdata1), .pending_o(pend1)
    );

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_gnt(int id);
        return (id == 0) ? gnt0 : gnt1;
    endfunction

    // Reference model: called when an acceptance is known to happen at the next edge.
    task automatic predict(int id, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
        exp_t        e;
        int unsigned wi;
        bit          known;
        logic [31:0] word;
        wi        = 32'(a[17:2]);
        e.acc_cyc = cyc + 1;
        e.err     = 1'b0;
        e.rdata   = '0;
        e.chk     = 1'b1;
        if (a[31:18] != 14'd0) begin
            e.err = 1'b1;
        end else begin
            known = (id == 0) ? (m0.exists(wi) != 0) : (m1.exists(wi) != 0);
            word  = '0;
            if (known) word = (id == 0) ? m0[wi] : m1[wi];
            e.rdata = word;
            e.chk   = known;
            if (w && (known || b == 4'hF)) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) word[8*i +: 8] = d[8*i +: 8];
                end
                if (id == 0) m0[wi] = word;
                else         m1[wi] = word;
            end
        end
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // Present a request at a negedge and hold it until granted (bounded).
    task automatic issue(int id, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
        bit done;
        done      = 1'b0;
        req[id]   = 1'b1;
        we[id]    = w;
        addr[id]  = a;
        be[id]    = b;
        wdata[id] = d;
        for (int n = 0; n < 16 && !done; n++) begin
            if (get_gnt(id)) begin
                predict(id, w, a, b, d);
                done = 1'b1;
            end
            @(negedge clk);
        end
        check($sformatf("grant_wait[%0d]", id), 64'(done), 64'd1);
    endtask

    task automatic idle(int id, int n);
        req[id] = 1'b0;
        we[id]  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Pops and compares one expected entry per response pulse.
    task automatic monitor();
        exp_t        e;
        logic        rv, er;
        logic [31:0] rd;
        int          lat, qs;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int id = 0; id < 2; id++) begin
                    rv  = (id == 0) ? rvalid0 : rvalid1;
                    er  = (id == 0) ? err0 : err1;
                    rd  = (id == 0) ? rdata0 : rdata1;
                    lat = (id == 0) ? LAT0 : LAT1;
                    qs  = (id == 0) ? q0.size() : q1.size();
                    if (rv) begin
                        if (qs == 0) begin
                            check($sformatf("unexpected_rvalid[%0d]", id), 64'(rv), 64'd0);
                        end else begin
                            if (id == 0) e = q0.pop_front();
                            else         e = q1.pop_front();
                            rsp_cnt[id]++;
                            if (er) err_cnt[id]++;
                            last_rdata[id] = rd;
                            check($sformatf("rsp_err[%0d]", id), 64'(er), 64'(e.err));
                            if (e.chk) check($sformatf("rsp_rdata[%0d]", id), 64'(rd), 64'(e.rdata));
                            check($sformatf("rsp_latency[%0d]", id), 64'(cyc - e.acc_cyc), 64'(lat - 1));
                        end
                    end else begin
                        check($sformatf("idle_zero[%0d]", id), 64'({er, rd}), 64'd0);
                    end
                end
            end
        end
    endtask

    initial begin
        logic [9:0] pat;
        int         k, n0, e0;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0;
            be[i] = '0; wdata[i] = '0; rsp_cnt[i] = 0; err_cnt[i] = 0; last_rdata[i] = '0;
        end
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_gnt0", 64'(gnt0), 64'd0);
        check("rst_rvalid0", 64'({rvalid0, err0, rdata0}), 64'd0);
        check("rst_pend0", 64'(pend0), 64'd0);
        check("rst_gnt1", 64'(gnt1), 64'd0);
        check("rst_rvalid1", 64'({rvalid1, err1, rdata1}), 64'd0);
        check("rst_pend1", 64'(pend1), 64'd0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("gnt0_after_reset", 64'(gnt0), 64'd1);
        check("gnt1_after_reset", 64'(gnt1), 64'd1);

        // Write then read back, latency 3, pending peaks at 2
        issue(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        issue(0, 1'b0, 32'h100, 4'hF, 32'h0);
        check("t1_pend_peak", 64'(pend0), 64'd2);
        idle(0, 6);
        check("t1_read_data", 64'(last_rdata[0]), 64'hDEADBEEF);
        check("t1_pend_drain", 64'(pend0), 64'd0);

        // Partial byte-enable write
        issue(0, 1'b1, 32'h40, 4'hF, 32'h11223344);
        issue(0, 1'b1, 32'h40, 4'b0101, 32'hAABBCCDD);
        issue(0, 1'b0, 32'h40, 4'h0, 32'h0);
        idle(0, 6);
        check("t2_byte_merge", 64'(last_rdata[0]), 64'h11BB33DD);

        // Out-of-range accesses error out and leave word 0 untouched
        issue(0, 1'b1, 32'h0, 4'hF, 32'h0BADF00D);
        idle(0, 4);
        e0 = err_cnt[0];
        issue(0, 1'b1, 32'h0004_0000, 4'hF, 32'hFFFFFFFF);
        issue(0, 1'b0, 32'h0004_0000, 4'hF, 32'h0);
        issue(0, 1'b0, 32'h0, 4'h0, 32'h0);
        idle(0, 6);
        check("t3_err_count", 64'(err_cnt[0] - e0), 64'd2);
        check("t3_word0_kept", 64'(last_rdata[0]), 64'h0BADF00D);

        // Back-to-back write/read of the same word
        issue(0, 1'b1, 32'h200, 4'hF, 32'h0);
        idle(0, 1);
        issue(0, 1'b1, 32'h200, 4'hF, 32'h5);
        issue(0, 1'b0, 32'h200, 4'h0, 32'h0);
        idle(0, 6);
        check("t6_read_new", 64'(last_rdata[0]), 64'h5);
        check("t6_drained", 64'(q0.size()), 64'd0);

        // Stall pattern: preload 8 words, reset, then 10 cycles of requests
        for (int i = 0; i < 8; i++) begin
            issue(1, 1'b1, 32'h1000 + 32'(4 * i), 4'hF, 32'hC0DE0000 + 32'(i));
        end
        idle(1, 10);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        @(negedge clk);
        pat = 10'b1111001111;
        k   = 0;
        n0  = rsp_cnt[1];
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t4_gnt_c%0d", i), 64'(gnt1), 64'(pat[9-i]));
            req[1]  = 1'b1;
            we[1]   = 1'b0;
            be[1]   = 4'h0;
            addr[1] = 32'h1000 + 32'(4 * k);
            if (gnt1) begin
                predict(1, 1'b0, addr[1], 4'h0, 32'h0);
                k++;
            end
            @(negedge clk);
        end
        idle(1, 10);
        check("t4_pulses", 64'(rsp_cnt[1] - n0), 64'd8);
        check("t4_last_data", 64'(last_rdata[1]), 64'hC0DE0007);

        // Reset with three reads in flight
        issue(1, 1'b0, 32'h1000, 4'h0, 32'h0);
        issue(1, 1'b0, 32'h1004, 4'h0, 32'h0);
        issue(1, 1'b0, 32'h1008, 4'h0, 32'h0);
        check("t5_pend_pre", 64'(pend1), 64'd3);
        req[1] = 1'b0;
        rst[1] = 1'b1;
        q1.delete();
        n0 = rsp_cnt[1];
        @(negedge clk);
        rst[1] = 1'b0;
        check("t5_gnt_in_reset", 64'(gnt1), 64'd0);
        check("t5_pend_reset", 64'(pend1), 64'd0);
        @(negedge clk);
        check("t5_gnt_after", 64'(gnt1), 64'd1);
        idle(1, 8);
        check("t5_no_rvalid", 64'(rsp_cnt[1] - n0), 64'd0);
        check("t5_pend_final", 64'(pend1), 64'd0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
